// File: rtl/spi_ram_arbiter.sv
// Round-robin arbiter sharing a single-port RAM between an SPI slave command stream
// and a local requester. One access in flight at a time; reads return three cycles after grant.
module spi_ram_arbiter #(
  parameter int unsigned ADDR_SIZE = 8,
  parameter int unsigned MEM_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [9:0]           rx_data,
  input  logic                 rx_valid,
  output logic [MEM_WIDTH-1:0] tx_data,
  output logic                 tx_valid,
  input  logic                 lcl_req,
  input  logic                 lcl_we,
  input  logic [ADDR_SIZE-1:0] lcl_addr,
  input  logic [MEM_WIDTH-1:0] lcl_din,
  output logic                 lcl_gnt,
  output logic [MEM_WIDTH-1:0] lcl_rdata,
  output logic                 lcl_rvalid,
  output logic                 ram_en,
  output logic                 ram_we,
  output logic [ADDR_SIZE-1:0] ram_addr,
  output logic [MEM_WIDTH-1:0] ram_din,
  input  logic [MEM_WIDTH-1:0] ram_dout,
  output logic                 spi_ovf,
  output logic                 busy
);

  typedef enum logic [1:0] {StIdle, StAccess, StRdCapture} state_e;

  state_e               state_q;
  logic [ADDR_SIZE-1:0] wr_addr_q, rd_addr_q;
  logic                 pend_q, pend_we_q;
  logic [ADDR_SIZE-1:0] pend_addr_q;
  logic [MEM_WIDTH-1:0] pend_din_q;
  logic                 last_lcl_q;
  logic                 op_spi_q, op_we_q;
  logic                 ovf_q;
  logic [MEM_WIDTH-1:0] tx_data_q, lcl_rdata_q;
  logic                 tx_valid_q, lcl_rvalid_q;
  logic                 ram_en_q, ram_we_q;
  logic [ADDR_SIZE-1:0] ram_addr_q;
  logic [MEM_WIDTH-1:0] ram_din_q;

  logic [1:0] cmd;
  logic [7:0] payload;
  logic       rx_op;
  logic       grant_spi, grant_lcl;

  assign cmd     = rx_data[9:8];
  assign payload = rx_data[7:0];
  // Commands 01 and 11 both queue a RAM operation.
  assign rx_op   = rx_valid & cmd[0];

  // A tie goes to whichever requester was not granted last.
  always_comb begin
    grant_spi = 1'b0;
    grant_lcl = 1'b0;
    if (state_q == StIdle) begin
      grant_spi = pend_q & (~lcl_req | last_lcl_q);
      grant_lcl = lcl_req & (~pend_q | ~last_lcl_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      wr_addr_q    <= '0;
      rd_addr_q    <= '0;
      pend_q       <= 1'b0;
      pend_we_q    <= 1'b0;
      pend_addr_q  <= '0;
      pend_din_q   <= '0;
      last_lcl_q   <= 1'b1;
      op_spi_q     <= 1'b0;
      op_we_q      <= 1'b0;
      ovf_q        <= 1'b0;
      tx_data_q    <= '0;
      tx_valid_q   <= 1'b0;
      lcl_rdata_q  <= '0;
      lcl_rvalid_q <= 1'b0;
      ram_en_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_din_q    <= '0;
    end else begin
      tx_valid_q   <= 1'b0;
      lcl_rvalid_q <= 1'b0;
      ram_en_q     <= 1'b0;
      ram_we_q     <= 1'b0;

      if (rx_valid && cmd == 2'b00) wr_addr_q <= ADDR_SIZE'(payload);
      if (rx_valid && cmd == 2'b10) rd_addr_q <= ADDR_SIZE'(payload);

      // The address is frozen into the pending op now; later 00/10 words cannot move it.
      if (rx_op) begin
        if (pend_q && !grant_spi) ovf_q <= 1'b1;
        pend_q      <= 1'b1;
        pend_we_q   <= ~cmd[1];
        pend_addr_q <= cmd[1] ? rd_addr_q : wr_addr_q;
        pend_din_q  <= MEM_WIDTH'(payload);
      end else if (grant_spi) begin
        pend_q <= 1'b0;
      end

      unique case (state_q)
        StIdle: begin
          if (grant_spi || grant_lcl) begin
            state_q    <= StAccess;
            op_spi_q   <= grant_spi;
            op_we_q    <= grant_spi ? pend_we_q : lcl_we;
            last_lcl_q <= grant_lcl;
            ram_en_q   <= 1'b1;
            ram_we_q   <= grant_spi ? pend_we_q : lcl_we;
            ram_addr_q <= grant_spi ? pend_addr_q : lcl_addr;
            ram_din_q  <= grant_spi ? pend_din_q : lcl_din;
          end
        end
        StAccess: begin
          state_q <= op_we_q ? StIdle : StRdCapture;
        end
        StRdCapture: begin
          if (op_spi_q) begin
            tx_data_q  <= ram_dout;
            tx_valid_q <= 1'b1;
          end else begin
            lcl_rdata_q  <= ram_dout;
            lcl_rvalid_q <= 1'b1;
          end
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Grant is decided combinationally in the IDLE cycle; masked so it reads 0 under reset.
  assign lcl_gnt    = grant_lcl & rst_n;
  assign tx_data    = tx_data_q;
  assign tx_valid   = tx_valid_q;
  assign lcl_rdata  = lcl_rdata_q;
  assign lcl_rvalid = lcl_rvalid_q;
  assign ram_en     = ram_en_q;
  assign ram_we     = ram_we_q;
  assign ram_addr   = ram_addr_q;
  assign ram_din    = ram_din_q;
  assign spi_ovf    = ovf_q;
  assign busy       = (state_q != StIdle) | pend_q;

endmodule
